// File: rtl/ans_freq_table_loader_if.sv
// Nibble-wide configuration bus feeding the ANS frequency table loader.
// master drives cfg_in/cfg_vld; the loader (slave) answers with cfg_rdy.
interface ans_freq_table_loader_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] cfg_in;
  logic             cfg_vld;
  logic             cfg_rdy;

  modport master (
    output cfg_in,
    output cfg_vld,
    input  cfg_rdy
  );

  modport slave (
    input  cfg_in,
    input  cfg_vld,
    output cfg_rdy
  );
endinterface

// File: rtl/ans_freq_table_loader.sv
// Loads a symbol frequency table nibble-serially and builds the count / inclusive prefix-sum
// tables for the ANS decoder. Optional ANS_ZERO_TOTAL_CHECK_EN flags an all-zero table as err.
module ans_freq_table_loader #(
  parameter int unsigned SYM_WIDTH = 4,
  parameter int unsigned SYM_COUNT = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      ena,
  input  logic                                      load_start,
  ans_freq_table_loader_if.slave                    cfg,
  output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked,
  output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  output logic                                      table_vld,
  output logic                                      busy,
  output logic                                      err
);

  localparam int unsigned CumWidth  = CNT_WIDTH + SYM_WIDTH;
  localparam int unsigned NibPerSym = CNT_WIDTH / 4;
  localparam int unsigned NibW      = (NibPerSym > 1) ? $clog2(NibPerSym) : 1;
  localparam int unsigned IdxW      = (SYM_COUNT > 1) ? $clog2(SYM_COUNT) : 1;
  localparam logic [NibW-1:0] LastNib = NibW'(NibPerSym - 1);
  localparam logic [IdxW-1:0] LastSym = IdxW'(SYM_COUNT - 1);

`ifdef ANS_ZERO_TOTAL_CHECK_EN
  localparam bit ZeroCheckEn = 1'b1;
`else
  localparam bit ZeroCheckEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAccum,
    StCheck,
    StReady,
    StError
  } state_e;

  state_e                state_q;
  logic [NibW-1:0]       nib_ptr_q;
  logic [IdxW-1:0]       sym_idx_q;
  logic [IdxW-1:0]       acc_idx_q;
  logic                  cfg_rdy_q;
  logic                  table_vld_q;
  logic                  busy_q;
  logic [CNT_WIDTH-1:0]  counts_q [SYM_COUNT];
  logic [CumWidth-1:0]   cum_q    [SYM_COUNT];

  logic [CumWidth-1:0]   acc_sum;
  logic [CumWidth-1:0]   total;

  assign total = cum_q[SYM_COUNT-1];

  // cumulative[-1] is taken as zero for the first symbol
  always_comb begin
    acc_sum = {{SYM_WIDTH{1'b0}}, counts_q[acc_idx_q]};
    if (acc_idx_q != '0) begin
      acc_sum = acc_sum + cum_q[acc_idx_q - 1'b1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      nib_ptr_q   <= '0;
      sym_idx_q   <= '0;
      acc_idx_q   <= '0;
      cfg_rdy_q   <= 1'b0;
      table_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < SYM_COUNT; i++) begin
        counts_q[i] <= '0;
        cum_q[i]    <= '0;
      end
    end else if (ena) begin
      if (load_start) begin
        // Restart from any state; tables keep their old contents until overwritten.
        state_q     <= StLoad;
        nib_ptr_q   <= '0;
        sym_idx_q   <= '0;
        acc_idx_q   <= '0;
        cfg_rdy_q   <= 1'b1;
        table_vld_q <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (cfg.cfg_vld && cfg_rdy_q) begin
              for (int n = 0; n < NibPerSym; n++) begin
                if (nib_ptr_q == NibW'(n)) begin
                  counts_q[sym_idx_q][n*4 +: 4] <= cfg.cfg_in;
                end
              end
              if (nib_ptr_q == LastNib) begin
                nib_ptr_q <= '0;
                if (sym_idx_q == LastSym) begin
                  state_q   <= StAccum;
                  sym_idx_q <= '0;
                  acc_idx_q <= '0;
                  cfg_rdy_q <= 1'b0;
                end else begin
                  sym_idx_q <= sym_idx_q + 1'b1;
                end
              end else begin
                nib_ptr_q <= nib_ptr_q + 1'b1;
              end
            end
          end
          StAccum: begin
            cum_q[acc_idx_q] <= acc_sum;
            if (acc_idx_q == LastSym) begin
              state_q <= StCheck;
            end else begin
              acc_idx_q <= acc_idx_q + 1'b1;
            end
          end
          StCheck: begin
            busy_q <= 1'b0;
            if (ZeroCheckEn && (total == '0)) begin
              state_q <= StError;
            end else begin
              state_q     <= StReady;
              table_vld_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ANS_ZERO_TOTAL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (ena) begin
      if (load_start) begin
        err_q <= 1'b0;
      end else if (state_q == StCheck && total == '0) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    counts_unpacked     = '0;
    cumulative_unpacked = '0;
    for (int i = 0; i < SYM_COUNT; i++) begin
      counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH]   = counts_q[i];
      cumulative_unpacked[i*CumWidth +: CumWidth] = cum_q[i];
    end
  end

  assign cfg.cfg_rdy = cfg_rdy_q;
  assign table_vld   = table_vld_q;
  assign busy        = busy_q;

endmodule

// File: doc/ans_freq_table_loader.md
# ans_freq_table_loader

Configuration controller for the ANS decoder datapath. It receives a symbol frequency table as a nibble stream on the shared 4-bit input bus, then builds the packed `counts_unpacked` and `cumulative_unpacked` vectors that the decoder and its ICDF lookup consume. While it loads, it holds the decoder off with `table_vld` low, and raises `table_vld` once the table is complete and consistent. It sits between the chip-level input mux and the `ans_decoder` table ports.

## Interface
Parameters:
- `SYM_WIDTH`, 4: symbol width in bits; also the nibble width of the configuration bus.
- `SYM_COUNT`, 16: number of symbols in the table.
- `CNT_WIDTH`, 8: width of each count. Must be a multiple of 4.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ena`, input, 1: global enable. When low, all state freezes.
- `load_start`, input, 1: single-cycle pulse that starts or restarts a table load.
- `cfg_in`, input, 4: configuration nibble.
- `cfg_vld`, input, 1: `cfg_in` is valid.
- `cfg_rdy`, output, 1: loader accepts a nibble this cycle.
- `counts_unpacked`, output, `CNT_WIDTH*SYM_COUNT`: count of symbol i at bits `[i*CNT_WIDTH +: CNT_WIDTH]`.
- `cumulative_unpacked`, output, `(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT`: inclusive prefix sum of symbol i at bits `[i*(CNT_WIDTH+SYM_WIDTH) +: (CNT_WIDTH+SYM_WIDTH)]`.
- `table_vld`, output, 1: tables are complete and usable. This signal gates the decoder.
- `busy`, output, 1: loader is in LOAD, ACCUM or CHECK.
- `err`, output, 1: the last load had a zero total.

## Operation
Reset value of every output and internal register is 0. The FSM resets to IDLE.

States:
- **IDLE**
  - `cfg_rdy` is 0.
  - `load_start` moves the FSM to LOAD.
- **LOAD**
  - `cfg_rdy` is 1.
  - A nibble is accepted when `cfg_vld && cfg_rdy && ena`.
  - Nibbles arrive symbol 0 first. Within a symbol, the least-significant nibble comes first, and each symbol takes `CNT_WIDTH/4` nibbles.
  - Counters: a nibble pointer wraps at `CNT_WIDTH/4`; a symbol index increments on each wrap.
  - Accepting the final nibble (symbol `SYM_COUNT-1`, last nibble) moves the FSM to ACCUM with the accumulation index reset to 0.
- **ACCUM**
  - One symbol per cycle: `cumulative[i] = cumulative[i-1] + counts[i]`, with `cumulative[-1] = 0`.
  - After i = `SYM_COUNT-1`, the FSM moves to CHECK.
- **CHECK**
  - Evaluates the total, `cumulative[SYM_COUNT-1]`, as described under Configuration.
  - Moves to READY or ERROR.
- **READY**
  - `table_vld` is 1.
  - `load_start` moves the FSM to LOAD.
- **ERROR**
  - `err` is 1 and `table_vld` is 0.
  - `load_start` clears `err` and moves the FSM to LOAD.

Arithmetic:
- Cumulative entries are `CNT_WIDTH+SYM_WIDTH` bits wide, so the sum cannot overflow (worst case 16 × 255 = 4080 < 4096).
- `counts` and `cumulative` are plain registers. They are never written outside LOAD and ACCUM.

Boundary conditions:
- `load_start` in any state, including LOAD, ACCUM and CHECK, aborts the current load:
  - clears the pointers, `table_vld` and `err`;
  - moves the FSM to LOAD;
  - leaves the table registers unchanged until they are overwritten.
- `load_start` together with a valid nibble in LOAD: the restart wins and the nibble is dropped.
- `cfg_vld` gaps of any length in LOAD are legal. No timeout.
- Asynchronous reset mid-load returns the FSM to IDLE with all tables cleared.
- `table_vld` drops in the same cycle the FSM leaves READY.

## Timing
- `cfg_rdy` is a registered output. It is valid in the first cycle after entering LOAD.
- Throughput: one nibble per cycle in LOAD.
- Latency, taking the edge that accepts the last nibble as E:
  - ACCUM occupies edges E+1 to E+`SYM_COUNT`;
  - CHECK resolves at edge E+`SYM_COUNT`+1;
  - `table_vld` (or `err`) is high after E+17 with the default parameters.
- `busy` is high from the edge that enters LOAD until the edge that enters READY or ERROR.
- `ena` low: no state, counter or table changes, and `cfg_rdy` holds its value. Nibbles offered while `ena` is low are not accepted.

## Configuration
- `ANS_ZERO_TOTAL_CHECK_EN` defined: CHECK moves to ERROR when the total is 0, and to READY otherwise.
- Macro not defined: CHECK always moves to READY, and `err` is tied to 0.

## Test plan
- Uniform table: `load_start`, then 32 nibbles (1,0 per symbol, all counts = 1). Expect `cumulative[i] = i+1`, total 16, and `table_vld` rising 17 cycles after the last nibble.
- Maximum table: all counts 0xFF. Expect `cumulative[15] = 4080`, no overflow, `counts_unpacked` all ones.
- Zero table with `ANS_ZERO_TOTAL_CHECK_EN` defined: expect `err = 1` and `table_vld = 0`. Without the macro: expect `table_vld = 1`.
- Backpressure: random one-to-five-cycle gaps in `cfg_vld`. Expect the same tables as with a gapless stream.
- Restart: `load_start` after 10 nibbles, then a full reload with counts = symbol index. Expect `cumulative[15] = 120` and no residue from the aborted load.
- Reset during ACCUM (cycle E+5): expect all outputs at 0 and the FSM in IDLE. Then `load_start` followed by the uniform table completes normally.
